// File: rtl/vend_fsm_core.sv
// Coin-accumulating vending controller: edge-detects debounced coin levels, accumulates
// credit, vends at PRICE and pays change/refunds as paced half-dollar/quarter pulses.
module vend_fsm_core #(
  parameter int CREDIT_W = 8,
  parameter int PRICE    = 100,
  parameter int Q_VAL    = 25,
  parameter int H_VAL    = 50,
  parameter int D_VAL    = 100,
  parameter int GAP      = 1
) (
  input  logic                CLK,
  input  logic                RES,
  input  logic                quarter_in,
  input  logic                halfDollar_in,
  input  logic                dollar_in,
  input  logic                cancel_in,
  output logic                guffin,
  output logic                quarter_out,
  output logic                halfDollar_out,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          state_code
);

  localparam int SUM_W = CREDIT_W + 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;

  localparam logic [SUM_W-1:0]    Q_S     = SUM_W'(Q_VAL);
  localparam logic [SUM_W-1:0]    H_S     = SUM_W'(H_VAL);
  localparam logic [SUM_W-1:0]    D_S     = SUM_W'(D_VAL);
  localparam logic [SUM_W-1:0]    PRICE_S = SUM_W'(PRICE);
  localparam logic [CREDIT_W-1:0] Q_C     = CREDIT_W'(Q_VAL);
  localparam logic [CREDIT_W-1:0] H_C     = CREDIT_W'(H_VAL);
  localparam logic [GAP_W-1:0]    GAP_C   = GAP_W'(GAP);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  state_t              state_r;
  logic [CREDIT_W-1:0] credit_r;
  logic [CREDIT_W-1:0] change_r;
  logic [GAP_W-1:0]    gap_r;
  logic                q_lvl_r, h_lvl_r, d_lvl_r, c_lvl_r;
  logic                ev_q_r, ev_h_r, ev_d_r, ev_c_r;
  logic                guffin_r, quarter_out_r, half_out_r, coin_reject_r;

  logic [SUM_W-1:0]    coin_val_s;
  logic [SUM_W-1:0]    sum_s;
  logic                coin_any_s;
  logic                multi_s;
  logic                ovf_s;

  // Coin priority select (dollar > half > quarter) and the candidate credit sum.
  always_comb begin
    coin_val_s = {SUM_W{1'b0}};
    coin_any_s = 1'b0;
    multi_s    = 1'b0;
    if (ev_d_r) begin
      coin_val_s = D_S;
      coin_any_s = 1'b1;
      multi_s    = ev_h_r | ev_q_r;
    end else if (ev_h_r) begin
      coin_val_s = H_S;
      coin_any_s = 1'b1;
      multi_s    = ev_q_r;
    end else if (ev_q_r) begin
      coin_val_s = Q_S;
      coin_any_s = 1'b1;
    end else begin
      coin_val_s = {SUM_W{1'b0}};
    end
    sum_s = {1'b0, credit_r} + coin_val_s;
    ovf_s = sum_s[CREDIT_W];
  end

  // Edge registers, controller state, credit/change bookkeeping and registered pulses.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_r       <= IDLE;
      credit_r      <= {CREDIT_W{1'b0}};
      change_r      <= {CREDIT_W{1'b0}};
      gap_r         <= {GAP_W{1'b0}};
      q_lvl_r       <= 1'b0;
      h_lvl_r       <= 1'b0;
      d_lvl_r       <= 1'b0;
      c_lvl_r       <= 1'b0;
      ev_q_r        <= 1'b0;
      ev_h_r        <= 1'b0;
      ev_d_r        <= 1'b0;
      ev_c_r        <= 1'b0;
      guffin_r      <= 1'b0;
      quarter_out_r <= 1'b0;
      half_out_r    <= 1'b0;
      coin_reject_r <= 1'b0;
    end else begin
      q_lvl_r       <= quarter_in;
      h_lvl_r       <= halfDollar_in;
      d_lvl_r       <= dollar_in;
      c_lvl_r       <= cancel_in;
      ev_q_r        <= quarter_in & ~q_lvl_r;
      ev_h_r        <= halfDollar_in & ~h_lvl_r;
      ev_d_r        <= dollar_in & ~d_lvl_r;
      ev_c_r        <= cancel_in & ~c_lvl_r;
      guffin_r      <= 1'b0;
      quarter_out_r <= 1'b0;
      half_out_r    <= 1'b0;
      coin_reject_r <= 1'b0;

      case (state_r)
        IDLE, ACCUM: begin
          if (coin_any_s) begin
            // An overflowing coin is refused outright; the credit is left untouched.
            coin_reject_r <= multi_s | ovf_s;
            if (!ovf_s) begin
              credit_r <= sum_s[CREDIT_W-1:0];
              if (sum_s >= PRICE_S) begin
                state_r  <= VEND;
                change_r <= CREDIT_W'(sum_s - PRICE_S);
                guffin_r <= 1'b1;
              end else begin
                state_r <= ACCUM;
              end
            end else begin
              state_r <= state_r;
            end
          end else if (ev_c_r && (credit_r != {CREDIT_W{1'b0}})) begin
            change_r <= credit_r;
            credit_r <= {CREDIT_W{1'b0}};
            gap_r    <= {GAP_W{1'b0}};
            state_r  <= CHANGE;
          end else begin
            state_r <= (credit_r != {CREDIT_W{1'b0}}) ? ACCUM : IDLE;
          end
        end

        VEND: begin
          credit_r      <= {CREDIT_W{1'b0}};
          coin_reject_r <= coin_any_s;
          gap_r         <= {GAP_W{1'b0}};
          state_r       <= (change_r != {CREDIT_W{1'b0}}) ? CHANGE : IDLE;
        end

        CHANGE: begin
          coin_reject_r <= coin_any_s;
          if (gap_r != {GAP_W{1'b0}}) begin
            gap_r <= gap_r - GAP_W'(1);
          end else if (change_r >= H_C) begin
            half_out_r <= 1'b1;
            change_r   <= change_r - H_C;
            gap_r      <= GAP_C;
          end else if (change_r >= Q_C) begin
            quarter_out_r <= 1'b1;
            change_r      <= change_r - Q_C;
            gap_r         <= GAP_C;
          end else begin
            change_r <= {CREDIT_W{1'b0}};
            state_r  <= IDLE;
          end
        end

        default: begin
          state_r  <= IDLE;
          credit_r <= {CREDIT_W{1'b0}};
          change_r <= {CREDIT_W{1'b0}};
          gap_r    <= {GAP_W{1'b0}};
        end
      endcase
    end
  end

  assign guffin         = guffin_r;
  assign quarter_out    = quarter_out_r;
  assign halfDollar_out = half_out_r;
  assign coin_reject    = coin_reject_r;
  assign credit         = credit_r;
  assign state_code     = state_r;
  assign busy           = (state_r == VEND) | (state_r == CHANGE);

  vend_fsm_core_chk u_chk (
    .CLK            (CLK),
    .RES            (RES),
    .guffin         (guffin),
    .quarter_out    (quarter_out),
    .halfDollar_out (halfDollar_out),
    .busy           (busy),
    .state_code     (state_code)
  );

endmodule

// Invariants on the vend/change pulse outputs and the busy flag.
module vend_fsm_core_chk (
  input logic       CLK,
  input logic       RES,
  input logic       guffin,
  input logic       quarter_out,
  input logic       halfDollar_out,
  input logic       busy,
  input logic [1:0] state_code
);

  a_pulse_onehot: assert property (@(posedge CLK) disable iff (!RES)
    $onehot0({guffin, quarter_out, halfDollar_out}))
    else $error("vend/change pulses overlap");

  a_busy_state: assert property (@(posedge CLK) disable iff (!RES)
    busy == state_code[1])
    else $error("busy does not track VEND/CHANGE");

endmodule
